// File: rtl/hs_bridge_pkg.sv
// Shared definitions for the hiscore RAM bridge: FSM states, Bagman RAM region map, unmapped read fill.
// Pure constants/helpers; no timing or flow control of its own.
package hs_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_GRANT,
        ST_READ,
        ST_RELEASE
    } hs_state_e;

    localparam logic [15:0] WORK_BASE = 16'h6000;
    localparam logic [15:0] WORK_SIZE = 16'h0800;
    localparam logic [15:0] VID_BASE  = 16'h9000;
    localparam logic [15:0] VID_SIZE  = 16'h0400;
    localparam logic [15:0] COL_BASE  = 16'h9800;
    localparam logic [15:0] COL_SIZE  = 16'h0400;

    localparam logic [10:0] WORK_MASK = 11'(WORK_SIZE - 16'd1);
    localparam logic [10:0] VID_MASK  = 11'(VID_SIZE - 16'd1);
    localparam logic [10:0] COL_MASK  = 11'(COL_SIZE - 16'd1);

    localparam logic [2:0] REGION_NONE = 3'b000;
    localparam logic [2:0] REGION_WORK = 3'b001;
    localparam logic [2:0] REGION_VID  = 3'b010;
    localparam logic [2:0] REGION_COL  = 3'b100;

    localparam logic [7:0] UNMAPPED_RD = 8'hFF;

    function automatic logic in_region(input logic [15:0] addr,
                                       input logic [15:0] base,
                                       input logic [15:0] size);
        return (addr & ~(size - 16'd1)) == base;
    endfunction

endpackage

// File: rtl/hs_addr_decode.sv
// Z80 address to one-hot RAM region select plus in-region offset.
// Purely combinational, zero latency; no flow control.
module hs_addr_decode
    import hs_bridge_pkg::*;
(
    input  logic [15:0] addr_i,
    output logic [2:0]  sel_o,
    output logic [10:0] addr_o
);

    always_comb begin
        sel_o  = REGION_NONE;
        addr_o = '0;
        if (in_region(addr_i, WORK_BASE, WORK_SIZE)) begin
            sel_o  = REGION_WORK;
            addr_o = addr_i[10:0] & WORK_MASK;
        end else if (in_region(addr_i, VID_BASE, VID_SIZE)) begin
            sel_o  = REGION_VID;
            addr_o = addr_i[10:0] & VID_MASK;
        end else if (in_region(addr_i, COL_BASE, COL_SIZE)) begin
            sel_o  = REGION_COL;
            addr_o = addr_i[10:0] & COL_MASK;
        end
    end

endmodule

// File: rtl/hs_ram_bridge.sv
// Hands Bagman work/video/colour RAM to the hiscore engine once the Z80 is parked in WAIT.
// Reads land RD_LAT+1 cycles after GRANT samples the address; writes pulse ram_we 1 cycle after the strobe.
module hs_ram_bridge
    import hs_bridge_pkg::*;
#(
    parameter int STALL_MAX = 255,
    parameter int RD_LAT    = 1
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [15:0] hs_address,
    input  logic [7:0]  hs_data_in,
    output logic [7:0]  hs_data_out,
    input  logic        hs_write_enable,
    input  logic        hs_read_intent,
    input  logic        hs_write_intent,
    input  logic        cpu_stalled,
    output logic        cpu_wait,
    output logic        hs_owns_ram,
    output logic [10:0] ram_addr,
    output logic [7:0]  ram_wdata,
    output logic        ram_we,
    output logic [2:0]  ram_sel,
    input  logic [7:0]  ram_rdata
);

    localparam int             LW        = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);
    localparam logic [7:0]     STALL_LIM = 8'(STALL_MAX);
    localparam logic [LW-1:0]  LAT_LIM   = LW'(RD_LAT);

    hs_state_e      state_q, state_d;
    logic [7:0]     stall_cnt_q, stall_cnt_d;
    logic [LW-1:0]  lat_cnt_q, lat_cnt_d;
    logic           rd_pend_q, rd_pend_d;
    logic           forced_q, forced_d;
    logic [7:0]     data_out_q, data_out_d;
    logic [15:0]    last_addr_q;
    logic [2:0]     sel_q;
    logic [10:0]    addr_q;
    logic [7:0]     wdata_q;
    logic           we_q;

    logic [2:0]     dec_sel;
    logic [10:0]    dec_addr;
    logic           any_intent;
    logic           addr_chg;
    logic           owning_q;
    logic           owning_d;

    hs_addr_decode u_decode (
        .addr_i (hs_address),
        .sel_o  (dec_sel),
        .addr_o (dec_addr)
    );

    assign any_intent = hs_read_intent | hs_write_intent;
    assign addr_chg   = (hs_address != last_addr_q);
    assign owning_q   = (state_q == ST_GRANT) || (state_q == ST_READ);
    assign owning_d   = (state_d == ST_GRANT) || (state_d == ST_READ);

    always_comb begin
        state_d     = state_q;
        stall_cnt_d = stall_cnt_q;
        lat_cnt_d   = lat_cnt_q;
        rd_pend_d   = rd_pend_q;
        forced_d    = forced_q;
        data_out_d  = data_out_q;
        case (state_q)
            ST_IDLE: begin
                stall_cnt_d = '0;
                rd_pend_d   = 1'b0;
                if (any_intent) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (stall_cnt_q != STALL_LIM) stall_cnt_d = stall_cnt_q + 8'd1;
                if (!any_intent) begin
                    state_d = ST_RELEASE;
                end else if (cpu_stalled) begin
                    state_d   = ST_GRANT;
                    rd_pend_d = 1'b1;
                end else if (stall_cnt_d == STALL_LIM) begin
                    state_d   = ST_GRANT;
                    rd_pend_d = 1'b1;
                    forced_d  = 1'b1;
                end
            end
            ST_GRANT: begin
                lat_cnt_d = '0;
                if (!any_intent) begin
                    state_d = ST_RELEASE;
                end else if (hs_write_enable) begin
                    // The write takes this cycle; any read it displaced is replayed afterwards.
                    rd_pend_d = rd_pend_q | addr_chg;
                end else if (hs_read_intent && (rd_pend_q || addr_chg)) begin
                    state_d   = ST_READ;
                    rd_pend_d = 1'b0;
                end
            end
            ST_READ: begin
                if (!any_intent) begin
                    state_d = ST_RELEASE;
                end else if (hs_write_enable) begin
                    state_d   = ST_GRANT;
                    rd_pend_d = 1'b1;
                end else if (addr_chg) begin
                    lat_cnt_d = '0;
                end else if (lat_cnt_q == LAT_LIM) begin
                    data_out_d = (sel_q == REGION_NONE) ? UNMAPPED_RD : ram_rdata;
                    state_d    = ST_GRANT;
                end else begin
                    lat_cnt_d = lat_cnt_q + LW'(1);
                end
            end
            ST_RELEASE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            stall_cnt_q <= '0;
            lat_cnt_q   <= '0;
            rd_pend_q   <= 1'b0;
            forced_q    <= 1'b0;
            data_out_q  <= '0;
            last_addr_q <= '0;
            sel_q       <= REGION_NONE;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            lat_cnt_q   <= lat_cnt_d;
            rd_pend_q   <= rd_pend_d;
            forced_q    <= forced_d;
            data_out_q  <= data_out_d;
            last_addr_q <= hs_address;
            // RAM port follows the engine address only while ownership is held next cycle.
            sel_q       <= owning_d ? dec_sel  : REGION_NONE;
            addr_q      <= owning_d ? dec_addr : '0;
            we_q        <= owning_q && owning_d && hs_write_enable && (dec_sel != REGION_NONE);
            if (owning_q && owning_d && hs_write_enable) wdata_q <= hs_data_in;
        end
    end

    assign hs_data_out = data_out_q;
    assign cpu_wait    = (state_q != ST_IDLE);
    assign hs_owns_ram = owning_q;
    assign ram_sel     = sel_q;
    assign ram_addr    = addr_q;
    assign ram_wdata   = wdata_q;
    assign ram_we      = we_q;

endmodule

// File: tb/tb_hs_ram_bridge.sv
// Self-checking bench for hs_ram_bridge with a registered RAM model behind the muxed port.
// Expected read data and write pulses are queued at stimulus time and popped when the DUT responds.
module tb_hs_ram_bridge;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] hs_address = '0;
    logic [7:0]  hs_data_in = '0;
    logic [7:0]  hs_data_out;
    logic        hs_write_enable = 1'b0;
    logic        hs_read_intent = 1'b0;
    logic        hs_write_intent = 1'b0;
    logic        cpu_stalled = 1'b0;
    logic        cpu_wait;
    logic        hs_owns_ram;
    logic [10:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic        ram_we;
    logic [2:0]  ram_sel;
    logic [7:0]  ram_rdata;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0]  rd_q [$];
    logic [21:0] wr_q [$];

    always #5 clk_sys = ~clk_sys;

    hs_ram_bridge #(.STALL_MAX(255), .RD_LAT(1)) dut (
        .clk_sys         (clk_sys),
        .reset           (reset),
        .hs_address      (hs_address),
        .hs_data_in      (hs_data_in),
        .hs_data_out     (hs_data_out),
        .hs_write_enable (hs_write_enable),
        .hs_read_intent  (hs_read_intent),
        .hs_write_intent (hs_write_intent),
        .cpu_stalled     (cpu_stalled),
        .cpu_wait        (cpu_wait),
        .hs_owns_ram     (hs_owns_ram),
        .ram_addr        (ram_addr),
        .ram_wdata       (ram_wdata),
        .ram_we          (ram_we),
        .ram_sel         (ram_sel),
        .ram_rdata       (ram_rdata)
    );

    // RAM model: unwritten cells hold a fixed address-derived pattern.
    logic [7:0]  mem [8192];
    bit          wrt [8192];
    logic [12:0] mdl_ix;

    function automatic logic [1:0] rid(input logic [2:0] s);
        case (s)
            3'b001:  return 2'd0;
            3'b010:  return 2'd1;
            3'b100:  return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    function automatic logic [7:0] dflt(input logic [12:0] ix);
        return ix[7:0] ^ 8'h79 ^ {ix[12:11], 6'b0};
    endfunction

    assign mdl_ix = {rid(ram_sel), ram_addr};

    always @(posedge clk_sys) begin
        if (ram_we && ram_sel != 3'b000) begin
            mem[mdl_ix] <= ram_wdata;
            wrt[mdl_ix] <= 1'b1;
        end
        ram_rdata <= (ram_sel == 3'b000) ? 8'h00 : (wrt[mdl_ix] ? mem[mdl_ix] : dflt(mdl_ix));
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic acquire(input logic rd, input logic wr, input logic [15:0] a);
        hs_address = a; hs_read_intent = rd; hs_write_intent = wr;
        tick();
        cpu_stalled = 1'b1;
        tick();
        n_cmp++;
        if (hs_owns_ram !== 1'b1) begin n_err++; $display("FAIL acquire_own: got %b want 1", hs_owns_ram); end
    endtask

    task automatic release_bus();
        hs_read_intent = 1'b0; hs_write_intent = 1'b0; hs_write_enable = 1'b0;
        tick();
        n_cmp++;
        if (hs_owns_ram !== 1'b0 || cpu_wait !== 1'b1) begin
            n_err++; $display("FAIL release_settle: own=%b wait=%b want own=0 wait=1", hs_owns_ram, cpu_wait);
        end
        cpu_stalled = 1'b0;
        tick();
        n_cmp++;
        if (cpu_wait !== 1'b0) begin n_err++; $display("FAIL release_idle: wait=%b want 0", cpu_wait); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        n_cmp++;
        if ({hs_data_out, cpu_wait, hs_owns_ram, ram_we, ram_sel, ram_addr, ram_wdata} !== 33'h0) begin
            n_err++; $display("FAIL reset_vals: got %h want 0", {hs_data_out, cpu_wait, hs_owns_ram, ram_we, ram_sel, ram_addr, ram_wdata});
        end
        reset = 1'b0;
        tick();
        n_cmp++;
        if (cpu_wait !== 1'b0 || hs_owns_ram !== 1'b0) begin n_err++; $display("FAIL reset_idle: wait=%b own=%b want 0 0", cpu_wait, hs_owns_ram); end
    endtask

    task automatic test_read_basic();
        logic [7:0] exp;
        hs_address = 16'h6123; hs_read_intent = 1'b1;
        tick();
        n_cmp++;
        if (cpu_wait !== 1'b1 || hs_owns_ram !== 1'b0) begin n_err++; $display("FAIL rd_wait: wait=%b own=%b want 1 0", cpu_wait, hs_owns_ram); end
        tick(); tick();
        cpu_stalled = 1'b1;
        tick();
        n_cmp++;
        if (hs_owns_ram !== 1'b1 || ram_sel !== 3'b001 || ram_addr !== 11'h123) begin
            n_err++; $display("FAIL rd_grant: own=%b sel=%b addr=%h want 1 001 123", hs_owns_ram, ram_sel, ram_addr);
        end
        rd_q.push_back(dflt({2'd0, 11'h123}));
        tick(); tick();
        n_cmp++;
        if (hs_data_out !== 8'h00) begin n_err++; $display("FAIL rd_early: got %h want 00", hs_data_out); end
        tick();
        exp = rd_q.pop_front();
        n_cmp++;
        if (hs_data_out !== exp) begin n_err++; $display("FAIL rd_data: got %h want %h", hs_data_out, exp); end
        release_bus();
        n_cmp++;
        if (hs_data_out !== exp) begin n_err++; $display("FAIL rd_hold: got %h want %h", hs_data_out, exp); end
    endtask

    task automatic test_write_burst();
        logic [7:0]  wd [3] = '{8'h11, 8'h22, 8'h33};
        logic [21:0] expw;
        logic [7:0]  exp;
        acquire(1'b0, 1'b1, 16'h9000);
        for (int i = 0; i < 3; i++) begin
            hs_address = 16'h9000 + 16'(i); hs_data_in = wd[i]; hs_write_enable = 1'b1;
            wr_q.push_back({3'b010, 11'(i), wd[i]});
            tick();
            n_cmp++;
            if (ram_we !== 1'b1) begin
                n_err++; $display("FAIL wr_pulse%0d: ram_we=%b want 1", i, ram_we);
            end else begin
                expw = wr_q.pop_front();
                if ({ram_sel, ram_addr, ram_wdata} !== expw) begin
                    n_err++; $display("FAIL wr_beat%0d: got %h want %h", i, {ram_sel, ram_addr, ram_wdata}, expw);
                end
            end
        end
        hs_write_enable = 1'b0; hs_address = 16'h9001; hs_read_intent = 1'b1;
        rd_q.push_back(8'h22);
        tick();
        n_cmp++;
        if (ram_we !== 1'b0) begin n_err++; $display("FAIL wr_stop: ram_we=%b want 0", ram_we); end
        tick(); tick();
        exp = rd_q.pop_front();
        n_cmp++;
        if (hs_data_out !== exp) begin n_err++; $display("FAIL wr_readback: got %h want %h", hs_data_out, exp); end
        n_cmp++;
        if (wr_q.size() != 0) begin n_err++; $display("FAIL wr_queue: left %0d want 0", wr_q.size()); end
        release_bus();
    endtask

    task automatic test_unmapped();
        logic [7:0] exp;
        acquire(1'b0, 1'b1, 16'h7000);
        hs_data_in = 8'h99; hs_write_enable = 1'b1;
        tick();
        n_cmp++;
        if (ram_we !== 1'b0 || ram_sel !== 3'b000) begin n_err++; $display("FAIL unm_write: we=%b sel=%b want 0 000", ram_we, ram_sel); end
        hs_write_enable = 1'b0;
        release_bus();
        acquire(1'b1, 1'b0, 16'h7000);
        rd_q.push_back(8'hFF);
        tick(); tick(); tick();
        exp = rd_q.pop_front();
        n_cmp++;
        if (hs_data_out !== exp) begin n_err++; $display("FAIL unm_read: got %h want %h", hs_data_out, exp); end
        release_bus();
    endtask

    task automatic test_write_wins();
        logic [7:0]  exp;
        logic [21:0] expw;
        acquire(1'b1, 1'b1, 16'h6010);
        rd_q.push_back(dflt({2'd0, 11'h010}));
        tick(); tick(); tick();
        exp = rd_q.pop_front();
        n_cmp++;
        if (hs_data_out !== exp) begin n_err++; $display("FAIL ww_first: got %h want %h", hs_data_out, exp); end
        hs_address = 16'h6020; hs_data_in = 8'hC3; hs_write_enable = 1'b1;
        wr_q.push_back({3'b001, 11'h020, 8'hC3});
        rd_q.push_back(8'hC3);
        tick();
        expw = wr_q.pop_front();
        n_cmp++;
        if (ram_we !== 1'b1 || {ram_sel, ram_addr, ram_wdata} !== expw) begin
            n_err++; $display("FAIL ww_write: we=%b got %h want 1 %h", ram_we, {ram_sel, ram_addr, ram_wdata}, expw);
        end
        hs_write_enable = 1'b0;
        tick(); tick(); tick();
        exp = rd_q.pop_front();
        n_cmp++;
        if (hs_data_out !== exp) begin n_err++; $display("FAIL ww_reread: got %h want %h", hs_data_out, exp); end
        release_bus();
    endtask

    task automatic test_forced();
        int n = 0;
        cpu_stalled = 1'b0; hs_address = 16'h9000; hs_read_intent = 1'b1;
        tick();
        while (hs_owns_ram !== 1'b1 && n < 400) begin
            n++;
            tick();
        end
        n_cmp++;
        if (n != 255) begin n_err++; $display("FAIL forced_grant: req cycles %0d want 255", n); end
        release_bus();
    endtask

    task automatic test_reset_mid_read();
        acquire(1'b1, 1'b0, 16'h9800);
        tick();
        reset = 1'b1; hs_read_intent = 1'b0; cpu_stalled = 1'b0;
        tick();
        n_cmp++;
        if ({hs_data_out, cpu_wait, hs_owns_ram, ram_we, ram_sel, ram_addr, ram_wdata} !== 33'h0) begin
            n_err++; $display("FAIL rst_mid: got %h want 0", {hs_data_out, cpu_wait, hs_owns_ram, ram_we, ram_sel, ram_addr, ram_wdata});
        end
        tick();
        reset = 1'b0;
        tick(); tick();
        n_cmp++;
        if (cpu_wait !== 1'b0 || hs_data_out !== 8'h00 || ram_we !== 1'b0) begin
            n_err++; $display("FAIL rst_after: wait=%b data=%h we=%b want 0 00 0", cpu_wait, hs_data_out, ram_we);
        end
        hs_read_intent = 1'b1;
        tick();
        n_cmp++;
        if (cpu_wait !== 1'b1 || hs_owns_ram !== 1'b0) begin n_err++; $display("FAIL rst_rereq: wait=%b own=%b want 1 0", cpu_wait, hs_owns_ram); end
        release_bus();
    endtask

    initial begin
        test_reset();
        test_read_basic();
        test_write_burst();
        test_unmapped();
        test_write_wins();
        test_forced();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
